ssp_tx_serializer: RTL and testbench



---
 rtl/ssp_tx_serializer.sv | 138 +++++++++++++
 tb/tb_ssp_tx_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_serializer.sv
// ssp_tx_serializer: SSP transmit serializer with a one-word holding buffer, frame sync and output enable.
// Define SSP_TX_PARITY_EN to append an even-parity bit after each frame's data bits.
module ssp_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  SSPCLKOUT,
    input  logic                  CLEAR,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  SSPTXD,
    output logic                  SSPOE_B,
    output logic                  SSPFSSOUT,
    output logic                  TX_BUSY,
    output logic                  FRAME_DONE
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] TOP = CW'(DATA_WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] hold, hold_n, shift_r, shift_n;
    logic [CW-1:0] count, count_n;
    logic hold_full, hold_full_n, txd_n, oe_b_n, fss_n;
    logic accept, last, pre_last;
`ifdef SSP_TX_PARITY_EN
    logic par, par_n, par_phase, par_phase_n;
`endif
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w << 1 : w >> 1;
    endfunction
    assign TX_READY = ~hold_full;
    assign TX_BUSY = (state != IDLE) || hold_full;
    assign FRAME_DONE = last;
    assign accept = TX_VALID && !hold_full;
`ifdef SSP_TX_PARITY_EN
    assign last = (state == SHIFT) && par_phase;
    assign pre_last = (state == SHIFT) && (count == '0) && !par_phase;
`else
    assign last = (state == SHIFT) && (count == '0);
    assign pre_last = (state == SHIFT) && (count == CW'(1));
`endif
    always_comb begin
        state_n = state;
        hold_n = accept ? TX_DATA : hold;
        hold_full_n = hold_full || accept;
        shift_n = shift_r;
        count_n = count;
        txd_n = SSPTXD;
        oe_b_n = SSPOE_B;
        // Sync pulse is raised entering the final cycle whenever a next word will be waiting.
        fss_n = pre_last && (hold_full || accept);
`ifdef SSP_TX_PARITY_EN
        par_n = par;
        par_phase_n = par_phase;
`endif
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n = SYNC;
                    shift_n = hold;
                    hold_full_n = 1'b0;
                    fss_n = 1'b1;
`ifdef SSP_TX_PARITY_EN
                    par_n = ^hold;
`endif
                end
            end
            SYNC: begin
                state_n = SHIFT;
                count_n = TOP;
                oe_b_n = 1'b0;
                txd_n = first_bit(shift_r);
                shift_n = advance(shift_r);
            end
            SHIFT: begin
                if (last && hold_full) begin
                    hold_full_n = 1'b0;
                    count_n = TOP;
                    txd_n = first_bit(hold);
                    shift_n = advance(hold);
`ifdef SSP_TX_PARITY_EN
                    par_n = ^hold;
                    par_phase_n = 1'b0;
`endif
                end else if (last) begin
                    state_n = IDLE;
                    oe_b_n = 1'b1;
                    txd_n = 1'b0;
                    count_n = TOP;
`ifdef SSP_TX_PARITY_EN
                    par_phase_n = 1'b0;
                end else if (count == '0) begin
                    par_phase_n = 1'b1;
                    txd_n = par;
`endif
                end else begin
                    count_n = count - 1'b1;
                    txd_n = first_bit(shift_r);
                    shift_n = advance(shift_r);
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge SSPCLKOUT or posedge CLEAR) begin
        if (CLEAR) begin
            state <= IDLE;
            hold <= '0;
            hold_full <= 1'b0;
            shift_r <= '0;
            count <= TOP;
            SSPTXD <= 1'b0;
            SSPOE_B <= 1'b1;
            SSPFSSOUT <= 1'b0;
`ifdef SSP_TX_PARITY_EN
            par <= 1'b0;
            par_phase <= 1'b0;
`endif
        end else begin
            state <= state_n;
            hold <= hold_n;
            hold_full <= hold_full_n;
            shift_r <= shift_n;
            count <= count_n;
            SSPTXD <= txd_n;
            SSPOE_B <= oe_b_n;
            SSPFSSOUT <= fss_n;
`ifdef SSP_TX_PARITY_EN
            par <= par_n;
            par_phase <= par_phase_n;
`endif
        end
    end
endmodule

// File: tb/tb_ssp_tx_serializer.sv
// tb_ssp_tx_serializer: checks MSB-first and LSB-first serializers against a frame-timeline model.
module tb_ssp_tx_serializer;
    localparam int DW = 8;
`ifdef SSP_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = DW + P;
    localparam int MAXC = 4000;
    logic clk = 1'b0, clear = 1'b1, valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic rdy, txd_m, oe, fss, busy, fd;
    logic rdy_l, txd_l, oe_l, fss_l, busy_l, fd_l;
    int cyc = 0, n_chk = 0, n_fail = 0, busy_until = -100, last_start = 0;
    logic exp_txd_m [MAXC];
    logic exp_txd_l [MAXC];
    logic exp_oe [MAXC];
    logic exp_fss [MAXC];
    logic exp_fd [MAXC];
    logic exp_rdy [MAXC];
    logic exp_busy [MAXC];
    logic obs_m [MAXC];
    logic obs_l [MAXC];
    logic obs_oe [MAXC];
    logic obs_fss [MAXC];
    logic obs_fd [MAXC];
    logic obs_rdy [MAXC];
    bit acc_prev = 1'b0, rand_en = 1'b0;
    logic [DW-1:0] dir_q [$];

    ssp_tx_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_m (
        .SSPCLKOUT(clk), .CLEAR(clear), .TX_DATA(data), .TX_VALID(valid), .TX_READY(rdy),
        .SSPTXD(txd_m), .SSPOE_B(oe), .SSPFSSOUT(fss), .TX_BUSY(busy), .FRAME_DONE(fd));
    ssp_tx_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_l (
        .SSPCLKOUT(clk), .CLEAR(clear), .TX_DATA(data), .TX_VALID(valid), .TX_READY(rdy_l),
        .SSPTXD(txd_l), .SSPOE_B(oe_l), .SSPFSSOUT(fss_l), .TX_BUSY(busy_l), .FRAME_DONE(fd_l));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic chk1(input string name, input logic act, input logic exp);
        chk8(name, {7'b0, act}, {7'b0, exp});
    endtask

    task automatic wipe(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_txd_m[c] = 1'b0; exp_txd_l[c] = 1'b0; exp_oe[c] = 1'b1; exp_fss[c] = 1'b0;
            exp_fd[c] = 1'b0; exp_rdy[c] = 1'b1; exp_busy[c] = 1'b0;
        end
    endtask

    // Word accepted at edge a: place its sync pulse, bits and buffer occupancy on the cycle timeline.
    task automatic sched(input int a, input logic [DW-1:0] w);
        int fs, st, hf;
        bit idle;
        if (a + 3 * L + 4 >= MAXC) return;
        idle = busy_until < a;
        fs = idle ? a + 1 : busy_until;
        st = fs + 1;
        hf = idle ? a + 1 : st;
        for (int c = a; c < hf; c++) exp_rdy[c] = 1'b0;
        for (int c = a; c < st + L; c++) exp_busy[c] = 1'b1;
        exp_fss[fs] = 1'b1;
        for (int i = 0; i < L; i++) begin
            exp_oe[st + i] = 1'b0;
            exp_txd_m[st + i] = (i < DW) ? w[DW - 1 - i] : ^w;
            exp_txd_l[st + i] = (i < DW) ? w[i] : ^w;
        end
        exp_fd[st + L - 1] = 1'b1;
        busy_until = st + L - 1;
        last_start = st;
    endtask

    task automatic step();
        @(negedge clk);
        if (acc_prev) begin
            valid = 1'b0;
            acc_prev = 1'b0;
        end
        if (!valid) begin
            data = DW'($urandom);
            if (dir_q.size() > 0) begin
                valid = 1'b1;
                data = dir_q.pop_front();
            end else if (rand_en && $urandom_range(0, 2) == 0) valid = 1'b1;
        end
        if (valid && exp_rdy[cyc]) begin
            sched(cyc + 1, data);
            acc_prev = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs_m[cyc] = txd_m; obs_l[cyc] = txd_l; obs_oe[cyc] = oe;
            obs_fss[cyc] = fss; obs_fd[cyc] = fd; obs_rdy[cyc] = rdy;
            chk1("txd_msb", txd_m, exp_txd_m[cyc]);
            chk1("txd_lsb", txd_l, exp_txd_l[cyc]);
            chk1("oe_b", oe, exp_oe[cyc]);
            chk1("oe_b_lsb", oe_l, exp_oe[cyc]);
            chk1("fss", fss, exp_fss[cyc]);
            chk1("fss_lsb", fss_l, exp_fss[cyc]);
            chk1("frame_done", fd, exp_fd[cyc]);
            chk1("frame_done_lsb", fd_l, exp_fd[cyc]);
            chk1("ready", rdy, exp_rdy[cyc]);
            chk1("ready_lsb", rdy_l, exp_rdy[cyc]);
            chk1("busy", busy, exp_busy[cyc]);
            chk1("busy_lsb", busy_l, exp_busy[cyc]);
        end
    end

    initial begin
        int st, n;
        logic [DW-1:0] vm, vo;
        wipe(0);
        repeat (3) @(negedge clk);
        clear = 1'b0;
        #1;
        chk1("rst_oe", oe, 1'b1);
        chk1("rst_fss", fss, 1'b0);
        chk1("rst_txd", txd_m, 1'b0);
        chk1("rst_ready", rdy, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        dir_q.push_back(8'hA5);
        step();
        st = last_start;
        repeat (L + 6) step();
        for (int i = 0; i < DW; i++) begin
            vm[DW - 1 - i] = exp_txd_m[st + i];
            vo[DW - 1 - i] = obs_m[st + i];
        end
        chk8("a5_model_bits", vm, 8'hA5);
        chk8("a5_dut_bits", vo, 8'hA5);
        chk1("a5_model_done", exp_fd[st + L - 1], 1'b1);
        chk1("a5_dut_done", obs_fd[st + L - 1], 1'b1);
        chk1("a5_dut_sync", obs_fss[st - 1], 1'b1);
        n = 0;
        for (int c = st - 3; c < st + L + 3; c++) if (!obs_oe[c]) n++;
        chk8("a5_oe_low_cycles", 8'(n), 8'(L));
        dir_q.push_back(8'h01);
        step();
        st = last_start;
        repeat (L + 6) step();
        for (int i = 0; i < DW; i++) vo[i] = obs_l[st + i];
        chk8("lsb_first_01", vo, 8'h01);
        chk1("lsb_first_bit", obs_l[st], 1'b1);
        dir_q.push_back(8'hF0);
        step();
        st = last_start;
        repeat (3) step();
        dir_q.push_back(8'h0F);
        repeat (2 * L + 8) step();
        chk1("b2b_sync_overlap", obs_fss[st + L - 1], 1'b1);
        chk1("b2b_ready_full", obs_rdy[st + L - 1], 1'b0);
        chk1("b2b_ready_free", obs_rdy[st + L], 1'b1);
        n = 0;
        while (n < 40 && !obs_oe[st + n]) n++;
        chk8("b2b_oe_contiguous", 8'(n), 8'(2 * L));
        for (int i = 0; i < DW; i++) begin
            vm[DW - 1 - i] = obs_m[st + i];
            vo[DW - 1 - i] = obs_m[st + L + i];
        end
        chk8("b2b_first_word", vm, 8'hF0);
        chk8("b2b_second_word", vo, 8'h0F);
`ifdef SSP_TX_PARITY_EN
        dir_q.push_back(8'h07);
        step();
        st = last_start;
        repeat (L + 6) step();
        chk1("parity_bit_07", obs_m[st + DW], 1'b1);
        chk1("parity_done_07", obs_fd[st + DW], 1'b1);
`endif
        rand_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        repeat (2 * L + 10) step();
        dir_q.push_back(8'hFF);
        dir_q.push_back(8'h3C);
        step();
        st = last_start;
        repeat (st - cyc + 3) step();
        chk1("pre_clear_bit4_oe", oe, 1'b0);
        chk1("pre_clear_ready", rdy, 1'b0);
        #2 clear = 1'b1;
        #1;
        chk1("clr_async_txd", txd_m, 1'b0);
        chk1("clr_async_oe", oe, 1'b1);
        chk1("clr_async_fss", fss, 1'b0);
        chk1("clr_async_done", fd, 1'b0);
        chk1("clr_async_ready", rdy, 1'b1);
        chk1("clr_async_busy", busy, 1'b0);
        wipe(cyc);
        busy_until = -100;
        valid = 1'b0;
        acc_prev = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (!oe) n++;
        end
        chk8("post_clear_oe_low", 8'(n), 8'd0);
        chk1("post_clear_ready", rdy, 1'b1);
        chk1("post_clear_busy", busy, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
